// File: rtl/mux4_rr_sel.sv
// Round-robin selector driving the 4:1 data mux select, with per-grant beat limit and valid/ready output.
// Optional MUX4_SEL_LOCK_EN adds a `lock` input that suppresses the beat-limit release while held.
module mux4_rr_sel #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
`ifdef MUX4_SEL_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic       last_beat
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [3:0]       r_grant, w_grant_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_cnt_nxt;

    logic       w_lock;
    logic       w_beat;
    logic       w_cnt_max;
    logic       w_rel_a;
    logic       w_rel_b;
    logic [3:0] w_arb_req;
    logic [1:0] w_arb_last;
    logic       w_found;
    logic [1:0] w_pick;

`ifdef MUX4_SEL_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign sel       = r_sel;
    assign grant     = r_grant;
    assign w_beat    = out_valid & out_ready;
    assign w_cnt_max = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_rel_a   = (r_state == ST_GRANT) & ~req[r_sel];
    assign w_rel_b   = (r_state == ST_GRANT) & w_beat & w_cnt_max & ~w_lock;

    // Arbitration input: in GRANT the search starts after the current holder,
    // which becomes the new pointer on release.
    always_comb begin
        w_arb_req  = req;
        w_arb_last = r_last;
        if (r_state == ST_GRANT) begin
            w_arb_last = r_sel;
            if (w_rel_a)
                w_arb_req = req & ~(4'b0001 << r_sel);
        end
    end

    always_comb begin
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_pick  = 2'd0;
        v_idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            v_idx = w_arb_last + 2'(k);
            if (!w_found && w_arb_req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_grant    <= 4'b0000;
            r_last     <= 2'd3;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick;
                    w_grant_nxt = 4'b0001 << w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (w_rel_a || w_rel_b) begin
                    w_last_nxt = r_sel;
                    w_cnt_nxt  = '0;
                    if (w_found) begin
                        w_sel_nxt   = w_pick;
                        w_grant_nxt = 4'b0001 << w_pick;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else if (w_beat && !w_cnt_max) begin
                    // Under lock the counter saturates at MAX_BEATS-1.
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_GRANT) & req[r_sel];
        last_beat = (r_state == ST_GRANT) & w_cnt_max & ~w_lock;
    end

endmodule
